// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, byte lanes, load extension.
// Optional access timeout is built when DMEM_TIMEOUT_EN is defined.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WrData,
    output logic              Stall,
    output logic              Done,
    output logic [31:0]       RdData,
    output logic              AccessErr,
    output logic              TimeoutErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rddata_q;
    logic              timeout_q;

    logic        req;
    logic        illegal_f3;
    logic        misaligned;
    logic        legal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_val;

    logic unused_addr;
    assign unused_addr = ^Addr[31:ADDR_W+2];

    always_comb begin
        req        = MemRead | MemWrite;
        // A simultaneous read and write is treated as a store.
        illegal_f3 = MemWrite ? (Funct3[2] || Funct3[1:0] == 2'b11)
                              : (Funct3 == 3'b011 || Funct3 == 3'b110 || Funct3 == 3'b111);
        misaligned = (Funct3[1:0] == 2'b01 && Addr[0]) ||
                     (Funct3[1:0] == 2'b10 && Addr[1:0] != 2'b00);
        legal      = !illegal_f3 && !misaligned;
        be_d       = 4'b0000;
        wdata_d    = WrData;
        case (Funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << Addr[1:0];
                wdata_d = {4{WrData[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << Addr[1:0];
                wdata_d = {2{WrData[15:0]}};
            end
            2'b10:   be_d = 4'b1111;
            default: be_d = 4'b0000;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'b0, shifted[7:0]};
            3'b101:  load_val = {16'b0, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CntW-1:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            rddata_q  <= '0;
            timeout_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    timeout_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                    if (req && legal) begin
                        addr_q  <= Addr[ADDR_W+1:2];
                        off_q   <= Addr[1:0];
                        f3_q    <= Funct3;
                        we_q    <= MemWrite;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            rddata_q <= load_val;
                        end
                        state_q <= StResp;
`ifdef DMEM_TIMEOUT_EN
                    end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                        if (!we_q) begin
                            rddata_q <= '0;
                        end
                        timeout_q <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset gates the combinational launch path so nothing is asserted while held.
    assign Stall     = reset && ((state_q == StIdle && req && legal) || state_q == StAccess);
    assign AccessErr = reset && state_q == StIdle && req && !legal;
    assign Done      = (state_q == StResp);
    assign mem_req   = (state_q == StAccess);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_be    = mem_req ? be_q : 4'b0000;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign RdData    = rddata_q;

`ifdef DMEM_TIMEOUT_EN
    assign TimeoutErr = (state_q == StResp) && timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC ^ timeout_q;
    assign TimeoutErr     = 1'b0;
`endif

endmodule
